usart_rx_ovs: RTL and testbench

USART_RX_OVS -- requirements
Module: usart_rx_ovs

---
 rtl/usart_rx_ovs.sv | 186 ++++++++++++++++++
 tb/tb_usart_rx_ovs.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usart_rx_ovs.sv
// Oversampling UART receiver: 2-flop input synchronizer, majority-of-3 mid-bit
// sampling, parity/stop checking, break detection and a small receive FIFO.
module usart_rx_ovs #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESC_W    = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PRESC_W-1:0]          prescaler,
  input  logic                        rx_pin,
  output logic [DATA_BITS-1:0]        data_out,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = $clog2(OVS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam int EW = DATA_BITS + 2;
  localparam logic [PW-1:0] PH_A    = PW'(OVS / 2 - 1);
  localparam logic [PW-1:0] PH_B    = PW'(OVS / 2);
  localparam logic [PW-1:0] PH_C    = PW'(OVS / 2 + 1);
  localparam logic [PW-1:0] PH_END  = PW'(OVS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, PUSH, BRKWAIT} state_t;

  state_t               state_reg, state_next;
  logic [1:0]           sync_reg;
  logic                 rxs, rxs_prev_reg;
  logic [PRESC_W-1:0]   tick_cnt_reg, presc_reg;
  logic                 tick;
  logic [PW-1:0]        phase_reg;
  logic [BW-1:0]        bit_cnt_reg;
  logic                 stop_cnt_reg;
  logic                 samp_a_reg, samp_b_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 fe_reg, pe_reg;
  logic                 start_edge, counting, maj, ph_c, ph_end;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 overrun_reg;
  logic                 push, pop, wr_en;
  logic [EW-1:0]        head;

  assign rxs        = sync_reg[1];
  assign start_edge = (state_reg == IDLE) && rxs_prev_reg && !rxs;
  assign tick       = (tick_cnt_reg == presc_reg);
  assign counting   = (state_reg == START) || (state_reg == DATA) ||
                      (state_reg == PARITY) || (state_reg == STOP);
  assign ph_c       = tick && counting && (phase_reg == PH_C);
  assign ph_end     = tick && counting && (phase_reg == PH_END);
  assign maj        = (samp_a_reg & samp_b_reg) | (samp_a_reg & rxs) | (samp_b_reg & rxs);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg     <= 2'b11;
      rxs_prev_reg <= 1'b1;
    end else begin
      sync_reg     <= {sync_reg[0], rx_pin};
      rxs_prev_reg <= rxs;
    end
  end

  // The prescaler is only re-read at a wrap so a change never shortens a running period.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt_reg <= '0;
      presc_reg    <= prescaler;
    end else if (start_edge) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
      presc_reg    <= prescaler;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_edge) state_next = START;
      START:   if (ph_c && maj) state_next = IDLE;
               else if (ph_end) state_next = DATA;
      DATA:    if (ph_end && bit_cnt_reg == LAST_BIT)
                 state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (ph_end) state_next = STOP;
      STOP:    if (ph_c && stop_cnt_reg == LAST_STOP) state_next = PUSH;
      PUSH:    state_next = (fe_reg && shift_reg == '0) ? BRKWAIT : IDLE;
      BRKWAIT: if (rxs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      samp_a_reg   <= 1'b1;
      samp_b_reg   <= 1'b1;
      shift_reg    <= '0;
      fe_reg       <= 1'b0;
      pe_reg       <= 1'b0;
    end else if (start_edge) begin
      phase_reg    <= '0;
      bit_cnt_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      fe_reg       <= 1'b0;
      pe_reg       <= 1'b0;
    end else if (tick && counting) begin
      phase_reg <= (phase_reg == PH_END) ? '0 : phase_reg + 1'b1;
      if (phase_reg == PH_A) samp_a_reg <= rxs;
      if (phase_reg == PH_B) samp_b_reg <= rxs;
      // Third sample is the live rxs; the bit is resolved on this tick.
      if (phase_reg == PH_C) begin
        case (state_reg)
          DATA:    shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
          PARITY:  pe_reg    <= maj ^ (^shift_reg) ^ PAR_ODD;
          STOP:    if (!maj) fe_reg <= 1'b1;
          default: ;
        endcase
      end
      if (phase_reg == PH_END) begin
        if (state_reg == DATA) bit_cnt_reg  <= bit_cnt_reg + 1'b1;
        if (state_reg == STOP) stop_cnt_reg <= stop_cnt_reg + 1'b1;
      end
    end
  end

  assign push  = (state_reg == PUSH);
  assign pop   = data_valid && data_ready;
  assign wr_en = push && ((count_reg != FULL_CNT) || pop);
  assign head  = mem[rd_ptr_reg];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_reg] <= {shift_reg, fe_reg, pe_reg};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && !pop)      count_reg <= count_reg + 1'b1;
      else if (!wr_en && pop) count_reg <= count_reg - 1'b1;
      if (push && !wr_en) overrun_reg <= 1'b1;
    end
  end

  // Head fields are masked while empty so stale RAM contents never reach the outputs.
  assign data_valid = (count_reg != '0);
  assign data_out   = data_valid ? head[EW-1:2] : '0;
  assign frame_err  = data_valid & head[1];
  assign parity_err = data_valid & head[0];
  assign overrun    = overrun_reg;
  assign busy       = (state_reg != IDLE);
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_usart_rx_ovs.sv
// Scoreboard bench: an 8N1 receiver and an 8E1 receiver fed from frame-level stimulus
// tasks; a negedge monitor pops expected entries whenever a DUT hands one over.
module tb_usart_rx_ovs;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] prescaler;
  logic        rx_a, rx_b, ready_a, ready_b;
  logic [7:0]  dout_a, dout_b;
  logic        valid_a, fe_a, pe_a, ovr_a, busy_a;
  logic        valid_b, fe_b, pe_b, ovr_b, busy_b;
  logic [2:0]  cnt_a, cnt_b;

  always #5 clock = ~clock;

  usart_rx_ovs dut_a (
    .clock(clock), .reset(reset), .prescaler(prescaler), .rx_pin(rx_a),
    .data_out(dout_a), .data_valid(valid_a), .data_ready(ready_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ovr_a), .busy(busy_a),
    .fifo_count(cnt_a)
  );

  usart_rx_ovs #(.PARITY_EN(1)) dut_b (
    .clock(clock), .reset(reset), .prescaler(prescaler), .rx_pin(rx_b),
    .data_out(dout_b), .data_valid(valid_b), .data_ready(ready_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ovr_b), .busy(busy_b),
    .fifo_count(cnt_b)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   errors = 0;
  int   checks = 0;
  int   bit_clks = 16;
  int   vcyc_a = 0;
  bit   rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clock) begin : monitor
    ent_t e;
    if (valid_a) vcyc_a++;
    if (valid_a && ready_a) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got data %0h fe %0b, no entry expected", dout_a, fe_a);
      end else begin
        e = qa.pop_front();
        $display("pop A data=%0h fe=%0b pe=%0b (exp %0h %0b %0b)", dout_a, fe_a, pe_a, e.d, e.fe, e.pe);
        chk("a_data", 32'(dout_a), 32'(e.d));
        chk("a_frame_err", 32'(fe_a), 32'(e.fe));
        chk("a_parity_err", 32'(pe_a), 32'(e.pe));
      end
    end
    if (valid_b && ready_b) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got data %0h fe %0b, no entry expected", dout_b, fe_b);
      end else begin
        e = qb.pop_front();
        $display("pop B data=%0h fe=%0b pe=%0b (exp %0h %0b %0b)", dout_b, fe_b, pe_b, e.d, e.fe, e.pe);
        chk("b_data", 32'(dout_b), 32'(e.d));
        chk("b_frame_err", 32'(fe_b), 32'(e.fe));
        chk("b_parity_err", 32'(pe_b), 32'(e.pe));
      end
    end
  end

  // Consumer on B optionally stalls at random; changed mid-cycle, well away from the monitor.
  initial begin
    ready_b = 1'b1;
    forever begin
      @(posedge clock); #2;
      ready_b = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  // Reference: an entry holds the data byte, frame_err = stop bit low,
  // parity_err = parity bit ^ XOR of data (even parity). Full FIFO drops the frame.
  task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit, input logic stop_ok);
    ent_t e;
    e.d  = d;
    e.fe = !stop_ok;
    e.pe = (sel == 1) ? (pbit ^ (^d)) : 1'b0;
    if (sel == 0) begin
      if (qa.size() < 4) qa.push_back(e);
    end else begin
      if (qb.size() < 4) qb.push_back(e);
    end
    set_rx(sel, 1'b0);
    hold(bit_clks);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      hold(bit_clks);
    end
    if (sel == 1) begin
      set_rx(sel, pbit);
      hold(bit_clks);
    end
    set_rx(sel, stop_ok);
    hold(bit_clks);
    set_rx(sel, 1'b1);
  endtask

  task automatic random_frames(input int n);
    logic [7:0] d;
    logic       s, p;
    for (int k = 0; k < n; k++) begin
      for (int sel = 0; sel < 2; sel++) begin
        d = 8'($urandom);
        s = ($urandom_range(0, 5) != 0);
        p = 1'($urandom_range(0, 1));
        send_frame(sel, d, p, s);
        hold($urandom_range(0, 3) + (s ? 0 : bit_clks));
      end
    end
  endtask

  initial begin : stim
    int v0;
    reset = 1'b1; prescaler = 16'd0;
    rx_a = 1'b1; rx_b = 1'b1; ready_a = 1'b1;
    hold(3);
    reset = 1'b0;
    hold(1);
    chk("rst_valid_a", 32'(valid_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_count_a", 32'(cnt_a), 0);
    chk("rst_ovr_a", 32'(ovr_a), 0);
    chk("rst_dout_a", 32'(dout_a), 0);
    chk("rst_valid_b", 32'(valid_b), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    hold(2 * bit_clks);

    // 8N1 0xA5: single entry, data_valid exactly one clock wide
    v0 = vcyc_a;
    send_frame(0, 8'hA5, 1'b0, 1'b1);
    hold(bit_clks);
    chk("a5_valid_width", 32'(vcyc_a - v0), 1);

    // even parity on B
    send_frame(1, 8'h03, 1'b1, 1'b1);
    hold(bit_clks);
    send_frame(1, 8'h03, 1'b0, 1'b1);
    hold(bit_clks);

    // false start
    set_rx(0, 1'b0);
    hold(4);
    chk("fstart_busy_hi", 32'(busy_a), 1);
    set_rx(0, 1'b1);
    hold(16);
    chk("fstart_busy_lo", 32'(busy_a), 0);
    chk("fstart_no_entry", 32'(valid_a), 0);
    hold(bit_clks);

    // break: one all-zero entry with frame_err, then a normal frame
    begin
      ent_t e;
      e.d = 8'h00; e.fe = 1'b1; e.pe = 1'b0;
      qa.push_back(e);
    end
    set_rx(0, 1'b0);
    hold(30 * bit_clks);
    chk("break_busy", 32'(busy_a), 1);
    set_rx(0, 1'b1);
    hold(2 * bit_clks);
    chk("break_idle", 32'(busy_a), 0);
    send_frame(0, 8'h3C, 1'b0, 1'b1);
    hold(2 * bit_clks);

    // overrun: 5 frames, no consumer
    ready_a = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i * 8'h11), 1'b0, 1'b1);
    hold(2 * bit_clks);
    chk("ovr_count", 32'(cnt_a), 4);
    chk("ovr_flag", 32'(ovr_a), 1);
    ready_a = 1'b1;
    hold(10);
    chk("ovr_drained", 32'(cnt_a), 0);
    chk("ovr_sticky", 32'(ovr_a), 1);

    // reset in the middle of data bit 4 of 0x5A
    set_rx(0, 1'b0);
    hold(bit_clks);
    for (int i = 0; i < 4; i++) begin
      set_rx(0, 1'((8'h5A >> i) & 8'h01));
      hold(bit_clks);
    end
    set_rx(0, 1'b1);
    hold(bit_clks / 2);
    chk("mid_busy_pre", 32'(busy_a), 1);
    reset = 1'b1;
    hold(1);
    reset = 1'b0;
    chk("mid_busy", 32'(busy_a), 0);
    chk("mid_valid", 32'(valid_a), 0);
    chk("mid_ovr", 32'(ovr_a), 0);
    chk("mid_count", 32'(cnt_a), 0);
    chk("mid_dout", 32'(dout_a), 0);
    chk("mid_fe", 32'(fe_a | pe_a), 0);
    hold(8 * bit_clks);
    chk("mid_no_entry", 32'(cnt_a), 0);
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    hold(2 * bit_clks);

    // random traffic, B consumer stalling, then with a slower tick
    rand_rdy = 1'b1;
    random_frames(8);
    prescaler = 16'd2;
    bit_clks  = 48;
    hold(bit_clks);
    random_frames(4);
    hold(2 * bit_clks);
    rand_rdy = 1'b0;
    hold(20);

    chk("end_qa_empty", 32'(qa.size()), 0);
    chk("end_qb_empty", 32'(qb.size()), 0);
    chk("end_busy_a", 32'(busy_a), 0);
    chk("end_count_b", 32'(cnt_b), 0);
    chk("end_ovr_b", 32'(ovr_b), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
